// File: rtl/tof_trigger_sequencer.sv
// Time-of-flight shot sequencer: fires one trigger output, times the first rising edge on a
// selected stop input (or a timeout), and streams one result per shot over valid/ready.
module tof_trigger_sequencer #(
  parameter int CNT_W       = 16,
  parameter int NUM_OUT     = 3,
  parameter int NUM_IN      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic               io_mainClk,
  input  logic               io_asyncReset_n,
  input  logic               io_cfg_start,
  input  logic               io_cfg_abort,
  input  logic [1:0]         io_cfg_outSel,
  input  logic [0:0]         io_cfg_inSel,
  input  logic [7:0]         io_cfg_pulseLen,
  input  logic [CNT_W-1:0]   io_cfg_timeout,
  input  logic [CNT_W-1:0]   io_cfg_holdoff,
  input  logic [7:0]         io_cfg_shots,
  output logic [NUM_OUT-1:0] io_trigsOut,
  input  logic [NUM_IN-1:0]  io_trigsIn,
  output logic               io_busy,
  output logic               io_done,
  output logic               io_result_valid,
  input  logic               io_result_ready,
  output logic [CNT_W-1:0]   io_result_payload_time,
  output logic               io_result_payload_tmo,
  output logic [7:0]         io_result_payload_shot
);

  typedef enum logic [2:0] {IDLE, FIRE, WAIT, REPORT, HOLDOFF} state_t;

  state_t                               state;
  logic [SYNC_STAGES-1:0][NUM_IN-1:0]   sync_q;
  logic [NUM_IN-1:0]                    prev_q, rise, rise_sh;
  logic [1:0]                           out_sel;
  logic [0:0]                           in_sel;
  logic [7:0]                           plen_q, shots_q, shot_idx, pulse_cnt;
  logic [CNT_W-1:0]                     tmo_q, hold_q, timer, hold_cnt;
  logic                                 stop, last_shot, hs;
  logic [7:0]                           plen_eff;

  function automatic logic [NUM_OUT-1:0] fire_mask(input logic [1:0] sel);
    return NUM_OUT'(1) << sel;
  endfunction

  // Synchronizer chain plus one edge register; runs in every state so HOLDOFF edges age out.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_trigsIn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign rise_sh   = rise >> in_sel;
  assign stop      = rise_sh[0] && (state == FIRE || state == WAIT);
  assign plen_eff  = (plen_q == 8'd0) ? 8'd1 : plen_q;
  assign last_shot = (shot_idx + 8'd1) == shots_q;
  assign hs        = (state == REPORT) && io_result_valid && io_result_ready;

  assign io_busy                = (state != IDLE);
  assign io_done                = hs && last_shot && !io_cfg_abort;
  assign io_result_payload_shot = shot_idx;

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state                  <= IDLE;
      io_trigsOut            <= '0;
      io_result_valid        <= 1'b0;
      io_result_payload_time <= '0;
      io_result_payload_tmo  <= 1'b0;
      out_sel                <= '0;
      in_sel                 <= '0;
      plen_q                 <= '0;
      shots_q                <= '0;
      tmo_q                  <= '0;
      hold_q                 <= '0;
      shot_idx               <= '0;
      pulse_cnt              <= '0;
      timer                  <= '0;
      hold_cnt               <= '0;
    end else if (io_cfg_abort) begin
      state           <= IDLE;
      io_trigsOut     <= '0;
      io_result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io_cfg_start && io_cfg_shots != 8'd0) begin
          out_sel     <= io_cfg_outSel;
          in_sel      <= io_cfg_inSel;
          plen_q      <= io_cfg_pulseLen;
          tmo_q       <= io_cfg_timeout;
          hold_q      <= io_cfg_holdoff;
          shots_q     <= io_cfg_shots;
          shot_idx    <= '0;
          io_trigsOut <= fire_mask(io_cfg_outSel);
          timer       <= '0;
          pulse_cnt   <= 8'd1;
          state       <= FIRE;
        end
        FIRE, WAIT: begin
          // Stop edge outranks a coincident timeout; either one truncates the pulse.
          if (stop || timer == tmo_q) begin
            io_result_payload_time <= timer;
            io_result_payload_tmo  <= !stop;
            io_result_valid        <= 1'b1;
            io_trigsOut            <= '0;
            state                  <= REPORT;
          end else begin
            timer <= timer + 1'b1;
            if (state == FIRE) begin
              if (pulse_cnt >= plen_eff) begin
                io_trigsOut <= '0;
                state       <= WAIT;
              end else begin
                pulse_cnt <= pulse_cnt + 8'd1;
              end
            end
          end
        end
        REPORT: if (hs) begin
          io_result_valid <= 1'b0;
          shot_idx        <= shot_idx + 8'd1;
          if (last_shot) begin
            state <= IDLE;
          end else if (hold_q == '0) begin
            io_trigsOut <= fire_mask(out_sel);
            timer       <= '0;
            pulse_cnt   <= 8'd1;
            state       <= FIRE;
          end else begin
            hold_cnt <= CNT_W'(1);
            state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == hold_q) begin
            io_trigsOut <= fire_mask(out_sel);
            timer       <= '0;
            pulse_cnt   <= 8'd1;
            state       <= FIRE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tof_trigger_sequencer.sv
// Directed bench for tof_trigger_sequencer: single-shot vector table plus hand-written
// multi-shot, abort, busy-start and reset sequences.
module tb_tof_trigger_sequencer;
  localparam int CNT_W = 16, NUM_OUT = 3, NUM_IN = 2;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               start = 0, abort = 0, ready = 0;
  logic [1:0]         out_sel = 0;
  logic [0:0]         in_sel = 0;
  logic [7:0]         plen = 0, shots = 0;
  logic [CNT_W-1:0]   tmo = 0, hold = 0;
  logic [NUM_OUT-1:0] trigs_out;
  logic [NUM_IN-1:0]  trigs_in = 0;
  logic               busy, done, valid, r_tmo;
  logic [CNT_W-1:0]   r_time;
  logic [7:0]         r_shot;

  tof_trigger_sequencer dut (
    .io_mainClk(clk), .io_asyncReset_n(rst_n),
    .io_cfg_start(start), .io_cfg_abort(abort), .io_cfg_outSel(out_sel), .io_cfg_inSel(in_sel),
    .io_cfg_pulseLen(plen), .io_cfg_timeout(tmo), .io_cfg_holdoff(hold), .io_cfg_shots(shots),
    .io_trigsOut(trigs_out), .io_trigsIn(trigs_in), .io_busy(busy), .io_done(done),
    .io_result_valid(valid), .io_result_ready(ready), .io_result_payload_time(r_time),
    .io_result_payload_tmo(r_tmo), .io_result_payload_shot(r_shot)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, done_cnt = 0;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int os, input int is, input int pl, input int to, input int ho,
                         input int sh);
    out_sel = 2'(os); in_sel = 1'(is); plen = 8'(pl); tmo = CNT_W'(to);
    hold = CNT_W'(ho); shots = 8'(sh);
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!valid && n < bound) begin @(negedge clk); n++; end
    if (!valid) chk("valid_wait_expired", 0, 1);
  endtask

  typedef struct {
    int plen; int sel; int isel; int to; int edge_at;
    int exp_time; int exp_tmo; int exp_mask; int exp_cnt;
  } vec_t;

  // edge_at: timer value at which the synchronized stop edge is seen (-1 = none).
  // Stimulus rises two negedges earlier to cover the two synchronizer flops.
  task automatic run_vec(input int idx, input vec_t v);
    int cnt = 0, stray = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    set_cfg(v.sel, v.isel, v.plen, v.to, 0, 1);
    for (int j = -2; j <= v.exp_time; j++) begin
      @(negedge clk);
      if (j >= 0) begin
        if (trigs_out != 0) begin
          if (trigs_out == NUM_OUT'(v.exp_mask)) cnt++; else stray++;
        end
        if (j == v.exp_time) chk({tag, "_valid_early"}, 32'(valid), 0);
      end
      start = (j == -1);
      trigs_in[v.isel]     = (v.edge_at >= 0 && j >= v.edge_at - 2);
      trigs_in[1 - v.isel] = (j >= 3);
    end
    @(negedge clk);
    chk({tag, "_pulse_cycles"}, cnt, v.exp_cnt);
    chk({tag, "_stray_trig"}, stray, 0);
    chk({tag, "_valid"}, 32'(valid), 1);
    chk({tag, "_time"}, 32'(r_time), v.exp_time);
    chk({tag, "_tmo"}, 32'(r_tmo), v.exp_tmo);
    chk({tag, "_shot"}, 32'(r_shot), 0);
    ready = 1'b1;
    #1 chk({tag, "_done"}, 32'(done), 1);
    @(negedge clk);
    ready = 1'b0;
    chk({tag, "_idle_after"}, {busy, valid, done}, 0);
    trigs_in = '0;
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    //          plen sel isel   to edge time tmo mask cnt
    vecs[0] = '{4,   1,  0,  1000, 37,  37,  0,  2,   4};
    vecs[1] = '{4,   0,  0,    50, -1,  50,  1,  1,   4};
    vecs[2] = '{4,   2,  0,    50, 50,  50,  0,  4,   4};
    vecs[3] = '{0,   0,  1,    20,  5,   5,  0,  1,   1};
    vecs[4] = '{10,  1,  0,     3, -1,   3,  1,  2,   4};
    vecs[5] = '{2,   3,  1,    10,  7,   7,  0,  0,   0};
    vecs[6] = '{1,   2,  0,     0,  0,   0,  0,  4,   1};
    vecs[7] = '{5,   0,  1,     0, -1,   0,  1,  1,   1};
    vecs[8] = '{3,   1,  1,   100,  1,   1,  0,  2,   2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {trigs_out, busy, done, valid, r_tmo}, 0);
    chk("reset_payload", {r_time, r_shot}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Three shots with holdoff and a stalled consumer
    begin
      logic [31:0] snap;
      int idle;
      done_cnt = 0;
      set_cfg(0, 0, 2, 20, 10, 3);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int s = 0; s < 3; s++) begin
        wait_valid(100);
        chk($sformatf("ms%0d_shot", s), 32'(r_shot), s);
        chk($sformatf("ms%0d_time", s), {r_tmo, r_time}, {1'b1, 16'd20});
        snap = {valid, r_tmo, r_time, r_shot};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("ms%0d_stall%0d", s, k), {valid, r_tmo, r_time, r_shot}, snap);
        end
        ready = 1'b1;
        #1 chk($sformatf("ms%0d_done", s), 32'(done), (s == 2) ? 1 : 0);
        @(negedge clk);
        ready = 1'b0;
        if (s < 2) begin
          idle = 0;
          while (trigs_out == 0 && idle < 50) begin idle++; @(negedge clk); end
          chk($sformatf("ms%0d_holdoff_gap", s), idle, 10);
        end
      end
      chk("ms_busy_end", 32'(busy), 0);
      chk("ms_done_count", done_cnt, 1);
    end
    repeat (3) @(negedge clk);

    // Abort in WAIT
    done_cnt = 0;
    set_cfg(1, 0, 2, 100, 0, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abw_pre_busy", 32'(busy), 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abw_after", {trigs_out, busy, valid, done}, 0);

    // Abort in REPORT, coincident with ready
    set_cfg(1, 0, 2, 5, 0, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid(40);
    abort = 1'b1; ready = 1'b1;
    #1 chk("abr_no_done", 32'(done), 0);
    @(negedge clk); abort = 1'b0; ready = 1'b0;
    chk("abr_after", {trigs_out, busy, valid}, 0);
    repeat (3) @(negedge clk);
    chk("abr_done_count", done_cnt, 0);

    // Start while busy is ignored
    begin
      int bad = 0;
      set_cfg(0, 0, 3, 30, 0, 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
      set_cfg(2, 0, 3, 7, 0, 4);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int k = 0; k < 40 && !valid; k++) begin
        if (trigs_out[2]) bad++;
        @(negedge clk);
      end
      chk("bs_no_refire", bad, 0);
      chk("bs_result", {valid, r_tmo, r_time}, {1'b1, 1'b1, 16'd30});
      ready = 1'b1;
      #1 chk("bs_done", 32'(done), 1);
      @(negedge clk); ready = 1'b0;
      chk("bs_idle", 32'(busy), 0);
    end

    // shots = 0 ignored
    set_cfg(0, 0, 3, 30, 0, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("zero_shots_busy", 32'(busy), 0);
    @(negedge clk);
    chk("zero_shots_trig", {trigs_out, busy}, 0);

    // Asynchronous reset mid-FIRE
    set_cfg(2, 0, 8, 100, 0, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("rst_pre_fire", {trigs_out, busy}, {3'b100, 1'b1});
    rst_n = 1'b0;
    #1 chk("rst_async", {trigs_out, busy, valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stays_idle", {trigs_out, busy, valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end
endmodule
